// File: rtl/axis_ema_pkg.sv
// rtl/axis_ema_pkg.sv - shared sample types and constants for the EMA stream chain
package axis_ema_pkg;

    localparam int DATA_W = 32;
    localparam logic [3:0] KEEP_ALL = 4'hF;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/boxcar_acc.sv
// rtl/boxcar_acc.sv - block accumulator, close detect and round-half-up shift for the boxcar decimator
module boxcar_acc
    import axis_ema_pkg::*;
#(
    parameter int LOG2_DECIM = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    beat,
    input  sample_t tdata,
    input  logic    tlast,
    output logic    close,
    output sample_t out_data,
    output logic    out_last
);

    localparam int ACC_W = DATA_W + LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);
    // Half an LSB of the shifted result; zero when there is no decimation.
    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'((1 << LOG2_DECIM) >> 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rounded;
    logic [CNT_W-1:0]        cnt;

    assign sum      = acc + ACC_W'(tdata);
    assign rounded  = sum + ROUND;
    assign close    = (cnt == CNT_LAST) || tlast;
    assign out_data = sample_t'(rounded >>> LOG2_DECIM);
    assign out_last = tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (beat) begin
            if (close) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_boxcar_decim.sv
// rtl/axis_boxcar_decim.sv - AXI-Stream boxcar decimator feeding axis_ema at the decimated rate
module axis_boxcar_decim
    import axis_ema_pkg::*;
#(
    parameter int LOG2_DECIM = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic [3:0]        S_AXIS_TKEEP,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic [3:0]        M_AXIS_TKEEP,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY
);

    logic    accept;
    logic    close;
    sample_t blk_data;
    logic    blk_last;
    logic    unused_keep;

    // Every accepted beat is a full sample, so the byte enables carry no information.
    assign unused_keep = ^S_AXIS_TKEEP;

    assign S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign M_AXIS_TKEEP  = KEEP_ALL;

    boxcar_acc #(
        .LOG2_DECIM(LOG2_DECIM)
    ) u_acc (
        .clk      (ACLK),
        .rst      (ARESET),
        .beat     (accept),
        .tdata    (sample_t'(S_AXIS_TDATA)),
        .tlast    (S_AXIS_TLAST),
        .close    (close),
        .out_data (blk_data),
        .out_last (blk_last)
    );

    // Single output slot; a closing beat can only be accepted when the slot is free or draining.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (accept && close) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= blk_data;
            M_AXIS_TLAST  <= blk_last;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_boxcar_decim.sv
// tb/tb_axis_boxcar_decim.sv - directed and soak scoreboard bench for axis_boxcar_decim
module tb_axis_boxcar_decim;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] S_AXIS_TDATA = '0;
    logic [3:0]  S_AXIS_TKEEP = 4'hF;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    int          out_count = 0;
    logic [31:0] last_data = '0;
    logic        last_last = 1'b0;
    bit          soak_en = 1'b0;
    longint      m_acc = 0;
    int          m_cnt = 0;

    always #5 ACLK = ~ACLK;

    axis_boxcar_decim #(.LOG2_DECIM(2)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge ACLK) begin : monitor
        logic [32:0] e;
        if (!ARESET && M_AXIS_TVALID && M_AXIS_TREADY) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL out_unexpected observed %h expected no output", M_AXIS_TDATA);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", M_AXIS_TDATA, e[31:0]);
                chk("out_last", {31'b0, M_AXIS_TLAST}, {31'b0, e[32]});
                chk("out_keep", {28'b0, M_AXIS_TKEEP}, 32'h0000_000F);
            end
            out_count++;
            last_data = M_AXIS_TDATA;
            last_last = M_AXIS_TLAST;
        end
    end

    task automatic model_accept(input logic [31:0] d, input logic l);
        longint r;
        m_acc += longint'(signed'(d));
        if (m_cnt == 3 || l) begin
            r = (m_acc + 2) >>> 2;
            exp_q.push_back({l, r[31:0]});
            m_acc = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
        if (soak_en) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge ACLK);
            if (S_AXIS_TREADY) begin
                model_accept(d, l);
                tick();
                S_AXIS_TVALID = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $error("FAIL send_timeout observed tready stuck 0 expected accept of %h", d);
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int exp_outs;
        int len;

        // Reset values
        #2;
        chk("rst_tvalid", {31'b0, M_AXIS_TVALID}, 0);
        chk("rst_tdata", M_AXIS_TDATA, 0);
        chk("rst_tlast", {31'b0, M_AXIS_TLAST}, 0);
        chk("rst_tready", {31'b0, S_AXIS_TREADY}, 1);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();

        // 1: 1,2,3,4 -> 3 one cycle after beat 4
        send(1, 0); send(2, 0); send(3, 0);
        chk("t1_no_early", {31'b0, M_AXIS_TVALID}, 0);
        send(4, 0);
        chk("t1_valid", {31'b0, M_AXIS_TVALID}, 1);
        chk("t1_data", M_AXIS_TDATA, 32'd3);
        chk("t1_last", {31'b0, M_AXIS_TLAST}, 0);
        tick();

        // 2: negative block rounds toward +inf
        send(-1, 0); send(-2, 0); send(-3, 0); send(-4, 0);
        tick();
        chk("t2_data", last_data, 32'hFFFF_FFFE);

        // 3: partial block flushed at TLAST, then a fresh block
        send(8, 0); send(8, 1);
        tick();
        chk("t3a_data", last_data, 32'd4);
        chk("t3a_last", {31'b0, last_last}, 1);
        send(4, 0); send(4, 0); send(4, 0); send(4, 0);
        tick();
        chk("t3b_data", last_data, 32'd4);
        chk("t3b_last", {31'b0, last_last}, 0);

        // 4: backpressure holds input and output
        base = out_count;
        M_AXIS_TREADY = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        S_AXIS_TDATA  = 32'd10;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t4_s_tready_low", {31'b0, S_AXIS_TREADY}, 0);
            chk("t4_hold_valid", {31'b0, M_AXIS_TVALID}, 1);
            chk("t4_hold_data", M_AXIS_TDATA, 32'd3);
            tick();
        end
        M_AXIS_TREADY = 1'b1;
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        tick();
        chk("t4_count", out_count - base, 2);
        chk("t4_data", last_data, 32'd25);

        // 5a: reset discards a pending output
        M_AXIS_TREADY = 1'b0;
        send(7, 0); send(7, 0); send(7, 0); send(7, 0);
        #2;
        ARESET = 1'b1;
        #1;
        chk("t5a_tvalid", {31'b0, M_AXIS_TVALID}, 0);
        exp_q.delete();
        m_acc = 0;
        m_cnt = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        M_AXIS_TREADY = 1'b1;
        tick();

        // 5b: reset mid-block leaves no residue
        send(5, 0); send(5, 0);
        #2;
        ARESET = 1'b1;
        #1;
        chk("t5b_tvalid", {31'b0, M_AXIS_TVALID}, 0);
        chk("t5b_tready", {31'b0, S_AXIS_TREADY}, 1);
        m_acc = 0;
        m_cnt = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();
        base = out_count;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        tick();
        chk("t5b_data", last_data, 32'd1);
        chk("t5b_count", out_count - base, 1);

        // 6: extremes
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 0);
        tick();
        chk("t6_max", last_data, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) send(32'h8000_0000, 0);
        tick();
        chk("t6_min", last_data, 32'h8000_0000);

        // Soak: random packets, random gaps and downstream stalls
        base = out_count;
        exp_outs = 0;
        soak_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send($urandom, (i == len - 1));
            end
            exp_outs += (len + 3) / 4;
        end
        soak_en = 1'b0;
        M_AXIS_TREADY = 1'b1;
        drain();
        tick();
        chk("soak_count", out_count - base, exp_outs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
